// File: rtl/drc_path_scheduler_pkg.sv
// Shared types and helpers for the DMA read-completion path scheduler.
// Descriptor addresses are carried in a fixed 32-bit field.
package drc_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } path_state_e;

  localparam logic [31:0] LP_4K_MASK     = 32'h0000_0FFF;
  localparam int          LP_DWEN_MAX_W  = 16;
  localparam int          LP_DESC_ADDR_W = 32;

  typedef struct packed {
    logic [LP_DESC_ADDR_W-1:0] addr;
    logic [7:0]                len;
  } burst_desc_t;

  function automatic logic [4:0] popcount_dwen(input logic [LP_DWEN_MAX_W-1:0] dwen);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < LP_DWEN_MAX_W; i++) cnt = cnt + 5'(dwen[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/drc_path_scheduler_if.sv
// Request and completion-beat signals between the splitter and the path scheduler.
interface drc_path_scheduler_if #(
  parameter int P_DATA_W = 128,
  parameter int P_ADDR_W = 32
);
  localparam int DW = P_DATA_W / 32;

  logic                req_valid;
  logic                req_ready;
  logic [7:0]          req_tag;
  logic [P_ADDR_W-1:0] req_dev_addr;
  logic [12:0]         req_bytes;
  logic                cpl_valid;
  logic [7:0]          cpl_tag;
  logic [DW-1:0]       cpl_dwen;

  modport master (
    output req_valid, req_tag, req_dev_addr, req_bytes,
    output cpl_valid, cpl_tag, cpl_dwen,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_tag, req_dev_addr, req_bytes,
    input  cpl_valid, cpl_tag, cpl_dwen,
    output req_ready
  );
endinterface

// File: rtl/drc_path_scheduler_tracker.sv
// One outstanding read: byte/beat accounting, burst descriptor generation,
// idle timeout and sticky error flags.
module drc_path_tracker
  import drc_pkg::*;
#(
  parameter int P_DW        = 4,
  parameter int P_ADDR_W    = 32,
  parameter int P_MAX_BURST = 16,
  parameter int P_TIMEOUT   = 4096
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                load,
  input  logic [7:0]          load_tag,
  input  logic [P_ADDR_W-1:0] load_addr,
  input  logic [12:0]         load_bytes,
  input  logic                match,
  input  logic [P_DW-1:0]     dwen,
  input  logic                err_clr,
  output logic                busy,
  output logic [7:0]          tag,
  output logic                desc_valid,
  output burst_desc_t         desc,
  output logic                err_timeout,
  output logic                err_overrun
);
  localparam int LP_TIMER_W = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
  localparam int LP_BEATS_W = $clog2(P_MAX_BURST + 1);
  localparam logic [LP_TIMER_W-1:0] LP_TIMER_LAST = LP_TIMER_W'(P_TIMEOUT - 1);

  path_state_e           state_q, state_d;
  logic [LP_BEATS_W-1:0] beats_q, beats_d;
  logic [LP_TIMER_W-1:0] timer_q, timer_d;
  logic [7:0]            tag_q, tag_d;
  logic [P_ADDR_W-1:0]   start_q, start_d, next_q, next_d;
  logic [12:0]           rem_q, rem_d;
  logic                  desc_vld_q, desc_vld_d;
  burst_desc_t           desc_q, desc_d;
  logic                  err_to_q, err_ov_q, to_set, ov_set;
  logic [12:0]           nbytes;

  assign nbytes = 13'({popcount_dwen(LP_DWEN_MAX_W'(dwen)), 2'b00});

  always_comb begin
    state_d    = state_q;
    beats_d    = beats_q;
    timer_d    = timer_q;
    tag_d      = tag_q;
    start_d    = start_q;
    next_d     = next_q;
    rem_d      = rem_q;
    desc_vld_d = 1'b0;
    desc_d     = desc_q;
    to_set     = 1'b0;
    ov_set     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = ACTIVE;
          tag_d   = load_tag;
          start_d = load_addr;
          next_d  = load_addr;
          rem_d   = load_bytes;
          beats_d = '0;
          timer_d = '0;
        end
      end
      ACTIVE: begin
        if (match) begin
          ov_set  = nbytes > rem_q;
          rem_d   = ov_set ? 13'd0 : rem_q - nbytes;
          next_d  = next_q + P_ADDR_W'(nbytes);
          beats_d = beats_q + LP_BEATS_W'(1);
          timer_d = '0;
          // Close on partial beat, full burst, end of transfer or a 4 KB page edge.
          if ((dwen != '1) || (beats_d == LP_BEATS_W'(P_MAX_BURST)) || (rem_d == 13'd0) ||
              ((next_d & P_ADDR_W'(LP_4K_MASK)) == '0)) begin
            desc_vld_d  = 1'b1;
            desc_d.addr = LP_DESC_ADDR_W'(start_q);
            desc_d.len  = 8'(beats_d - LP_BEATS_W'(1));
            start_d     = next_d;
            beats_d     = '0;
          end
          if (rem_d == 13'd0) state_d = IDLE;
        end else if (timer_q == LP_TIMER_LAST) begin
          to_set  = 1'b1;
          timer_d = '0;
          beats_d = '0;
          state_d = IDLE;
          if (beats_q != '0) begin
            desc_vld_d  = 1'b1;
            desc_d.addr = LP_DESC_ADDR_W'(start_q);
            desc_d.len  = 8'(beats_q - LP_BEATS_W'(1));
          end
        end else begin
          timer_d = timer_q + LP_TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      beats_q    <= '0;
      timer_q    <= '0;
      desc_vld_q <= 1'b0;
      desc_q     <= '0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      beats_q    <= beats_d;
      timer_q    <= timer_d;
      desc_vld_q <= desc_vld_d;
      desc_q     <= desc_d;
      err_to_q   <= (err_to_q & ~err_clr) | to_set;
      err_ov_q   <= (err_ov_q & ~err_clr) | ov_set;
    end
  end

  // Transfer bookkeeping is reloaded on every allocation, so it carries no reset.
  always_ff @(posedge i_clk) begin
    tag_q   <= tag_d;
    start_q <= start_d;
    next_q  <= next_d;
    rem_q   <= rem_d;
  end

  assign busy        = (state_q == ACTIVE);
  assign tag         = tag_q;
  assign desc_valid  = desc_vld_q;
  assign desc        = desc_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule

// File: rtl/drc_path_scheduler.sv
// N-path tracker for PCIe DMA read completions: allocates paths to requests,
// routes completion beats by tag and reports per-path AXI burst descriptors.
module drc_path_scheduler
  import drc_pkg::*;
#(
  parameter int P_PATHS     = 4,
  parameter int P_DATA_W    = 128,
  parameter int P_ADDR_W    = 32,
  parameter int P_MAX_BURST = 16,
  parameter int P_TIMEOUT   = 4096
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  drc_path_scheduler_if.slave         bus,
  input  logic [P_PATHS-1:0]          path_credit_ok,
  output logic [P_PATHS-1:0]          path_wr_en,
  output logic [P_PATHS-1:0]          desc_valid,
  output logic [P_PATHS*P_ADDR_W-1:0] desc_addr,
  output logic [P_PATHS*8-1:0]        desc_len,
  output logic [P_PATHS-1:0]          path_busy,
  output logic                        cpl_unexpected,
  output logic [P_PATHS-1:0]          err_timeout,
  output logic [P_PATHS-1:0]          err_overrun,
  input  logic                        err_clr,
  output logic                        all_idle
);
  localparam int DW = P_DATA_W / 32;

  logic [P_PATHS-1:0] can_start, load, hit, match;
  logic               alloc_found, match_found, unexp_q;
  logic [7:0]         path_tag [P_PATHS];
  burst_desc_t        desc [P_PATHS];

  assign can_start     = ~path_busy & path_credit_ok;
  assign bus.req_ready = bus.req_valid & (|can_start);

  // Lowest index wins both for allocation and for duplicate-tag completions.
  always_comb begin
    load        = '0;
    match       = '0;
    alloc_found = 1'b0;
    match_found = 1'b0;
    for (int i = 0; i < P_PATHS; i++) begin
      if (can_start[i] && !alloc_found) begin
        load[i]     = bus.req_valid;
        alloc_found = 1'b1;
      end
      if (hit[i] && !match_found) begin
        match[i]    = 1'b1;
        match_found = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < P_PATHS; g++) begin : g_path
    assign hit[g] = path_busy[g] & bus.cpl_valid & (bus.cpl_tag == path_tag[g]) & (|bus.cpl_dwen);

    drc_path_tracker #(
      .P_DW        (DW),
      .P_ADDR_W    (P_ADDR_W),
      .P_MAX_BURST (P_MAX_BURST),
      .P_TIMEOUT   (P_TIMEOUT)
    ) u_tracker (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .load        (load[g]),
      .load_tag    (bus.req_tag),
      .load_addr   (bus.req_dev_addr),
      .load_bytes  (bus.req_bytes),
      .match       (match[g]),
      .dwen        (bus.cpl_dwen),
      .err_clr     (err_clr),
      .busy        (path_busy[g]),
      .tag         (path_tag[g]),
      .desc_valid  (desc_valid[g]),
      .desc        (desc[g]),
      .err_timeout (err_timeout[g]),
      .err_overrun (err_overrun[g])
    );

    assign desc_addr[g*P_ADDR_W +: P_ADDR_W] = P_ADDR_W'(desc[g].addr);
    assign desc_len[g*8 +: 8]                = desc[g].len;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) unexp_q <= 1'b0;
    else       unexp_q <= bus.cpl_valid & (|bus.cpl_dwen) & ~(|hit);
  end

  assign path_wr_en     = match;
  assign cpl_unexpected = unexp_q;
  assign all_idle       = ~(|path_busy);

endmodule

// File: tb/tb_drc_path_scheduler.sv
// Scoreboard bench: two schedulers (max burst 16 and 8) driven by identical stimulus.
module tb_drc_path_scheduler;
  import drc_pkg::*;

  localparam int NP = 4;
  localparam int AW = 32;

  typedef struct {
    int          path;
    logic [31:0] addr;
    int          len;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  logic        req_valid, cpl_valid, err_clr;
  logic [7:0]  req_tag, cpl_tag;
  logic [31:0] req_dev_addr;
  logic [12:0] req_bytes;
  logic [3:0]  cpl_dwen, path_credit_ok;

  logic [NP-1:0]    a_wr_en, a_dv, a_busy, a_eto, a_eov, b_wr_en, b_dv, b_busy, b_eto, b_eov;
  logic [NP*AW-1:0] a_daddr, b_daddr;
  logic [NP*8-1:0]  a_dlen, b_dlen;
  logic             a_unexp, a_idle, b_unexp, b_idle;

  exp_t q_a[$], q_b[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  drc_path_scheduler_if #(.P_DATA_W(128), .P_ADDR_W(AW)) bus_a ();
  drc_path_scheduler_if #(.P_DATA_W(128), .P_ADDR_W(AW)) bus_b ();

  assign bus_a.req_valid = req_valid;    assign bus_b.req_valid = req_valid;
  assign bus_a.req_tag = req_tag;        assign bus_b.req_tag = req_tag;
  assign bus_a.req_dev_addr = req_dev_addr; assign bus_b.req_dev_addr = req_dev_addr;
  assign bus_a.req_bytes = req_bytes;    assign bus_b.req_bytes = req_bytes;
  assign bus_a.cpl_valid = cpl_valid;    assign bus_b.cpl_valid = cpl_valid;
  assign bus_a.cpl_tag = cpl_tag;        assign bus_b.cpl_tag = cpl_tag;
  assign bus_a.cpl_dwen = cpl_dwen;      assign bus_b.cpl_dwen = cpl_dwen;

  drc_path_scheduler #(.P_PATHS(NP), .P_DATA_W(128), .P_ADDR_W(AW), .P_MAX_BURST(16), .P_TIMEOUT(64)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus_a), .path_credit_ok(path_credit_ok),
    .path_wr_en(a_wr_en), .desc_valid(a_dv), .desc_addr(a_daddr), .desc_len(a_dlen),
    .path_busy(a_busy), .cpl_unexpected(a_unexp), .err_timeout(a_eto), .err_overrun(a_eov),
    .err_clr(err_clr), .all_idle(a_idle));

  drc_path_scheduler #(.P_PATHS(NP), .P_DATA_W(128), .P_ADDR_W(AW), .P_MAX_BURST(8), .P_TIMEOUT(64)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus_b), .path_credit_ok(path_credit_ok),
    .path_wr_en(b_wr_en), .desc_valid(b_dv), .desc_addr(b_daddr), .desc_len(b_dlen),
    .path_busy(b_busy), .cpl_unexpected(b_unexp), .err_timeout(b_eto), .err_overrun(b_eov),
    .err_clr(err_clr), .all_idle(b_idle));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge i_clk) begin
    for (int p = 0; p < NP; p++) begin
      if (a_dv[p]) begin
        if (q_a.size() == 0) check_eq("descA_extra", 64'(q_a.size()), 64'd1);
        else begin
          mon_e = q_a.pop_front();
          check_eq("descA_path", 64'(p), 64'(mon_e.path));
          check_eq("descA_addr", 64'(a_daddr[p*AW +: AW]), 64'(mon_e.addr));
          check_eq("descA_len", 64'(a_dlen[p*8 +: 8]), 64'(mon_e.len));
        end
      end
      if (b_dv[p]) begin
        if (q_b.size() == 0) check_eq("descB_extra", 64'(q_b.size()), 64'd1);
        else begin
          mon_e = q_b.pop_front();
          check_eq("descB_path", 64'(p), 64'(mon_e.path));
          check_eq("descB_addr", 64'(b_daddr[p*AW +: AW]), 64'(mon_e.addr));
          check_eq("descB_len", 64'(b_dlen[p*8 +: 8]), 64'(mon_e.len));
        end
      end
    end
  end

  task automatic send_req(input logic [7:0] tag, input logic [31:0] addr, input int bytes, input logic exp_rdy);
    req_valid = 1'b1; req_tag = tag; req_dev_addr = addr; req_bytes = 13'(bytes);
    #1;
    check_eq("req_ready_a", 64'(bus_a.req_ready), 64'(exp_rdy));
    check_eq("req_ready_b", 64'(bus_b.req_ready), 64'(exp_rdy));
    @(negedge i_clk);
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] tag, input logic [3:0] dwen, input logic [3:0] exp_wr, input logic exp_unexp);
    cpl_valid = 1'b1; cpl_tag = tag; cpl_dwen = dwen;
    #1;
    check_eq("wr_en_a", 64'(a_wr_en), 64'(exp_wr));
    check_eq("wr_en_b", 64'(b_wr_en), 64'(exp_wr));
    @(negedge i_clk);
    cpl_valid = 1'b0;
    check_eq("unexp_a", 64'(a_unexp), 64'(exp_unexp));
    check_eq("unexp_b", 64'(b_unexp), 64'(exp_unexp));
  endtask

  // Reference burst split for both max-burst settings; full beats then a partial tail.
  task automatic xfer(input int path, input logic [7:0] tag, input logic [31:0] addr, input int bytes);
    logic [31:0] nxt, sa, sb;
    int ba, bb, rem, n;
    logic [3:0] dwen;
    logic edge_close;
    send_req(tag, addr, bytes, 1'b1);
    nxt = addr; sa = addr; sb = addr; ba = 0; bb = 0; rem = bytes;
    while (rem > 0) begin
      n = (rem >= 16) ? 16 : rem;
      dwen = 4'((1 << (n / 4)) - 1);
      rem -= n; nxt += 32'(n); ba++; bb++;
      edge_close = (n < 16) || (rem == 0) || (nxt[11:0] == 12'h000);
      if (edge_close || ba == 16) begin q_a.push_back('{path, sa, ba - 1}); sa = nxt; ba = 0; end
      if (edge_close || bb == 8)  begin q_b.push_back('{path, sb, bb - 1}); sb = nxt; bb = 0; end
      send_beat(tag, dwen, 4'(1 << path), 1'b0);
    end
    check_eq("idle_after_a", 64'(a_idle), 64'd1);
    check_eq("idle_after_b", 64'(b_idle), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; req_valid = 1'b0; req_tag = '0; req_dev_addr = '0; req_bytes = '0;
    cpl_valid = 1'b0; cpl_tag = '0; cpl_dwen = '0; path_credit_ok = 4'b1111; err_clr = 1'b0;
    repeat (2) @(negedge i_clk);
    check_eq("rst_idle_a", 64'(a_idle), 64'd1);
    check_eq("rst_idle_b", 64'(b_idle), 64'd1);
    check_eq("rst_busy_a", 64'(a_busy), 64'd0);
    check_eq("rst_outs_a", {a_dv, a_eto, a_eov, a_unexp, a_dlen}, 64'd0);
    check_eq("rst_addr_a", 64'(a_daddr), 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);

    xfer(0, 8'h05, 32'h0000_1000, 256);
    xfer(0, 8'h06, 32'h0000_0000, 512);
    xfer(0, 8'h0C, 32'h0000_0FC0, 128);
    xfer(0, 8'h0B, 32'h0000_3000, 20);

    // Overrun: 16 bytes delivered against an 8-byte request.
    send_req(8'h09, 32'h0000_4000, 8, 1'b1);
    q_a.push_back('{0, 32'h0000_4000, 0});
    q_b.push_back('{0, 32'h0000_4000, 0});
    send_beat(8'h09, 4'hF, 4'b0001, 1'b0);
    check_eq("overrun_a", 64'(a_eov), 64'b0001);
    check_eq("overrun_b", 64'(b_eov), 64'b0001);
    check_eq("overrun_busy_a", 64'(a_busy), 64'd0);

    // Timeout after three beats of a four-beat transfer.
    send_req(8'h07, 32'h0000_2000, 64, 1'b1);
    repeat (3) send_beat(8'h07, 4'hF, 4'b0001, 1'b0);
    q_a.push_back('{0, 32'h0000_2000, 2});
    q_b.push_back('{0, 32'h0000_2000, 2});
    repeat (63) @(negedge i_clk);
    check_eq("to_early_a", 64'(a_eto), 64'd0);
    check_eq("to_early_busy_b", 64'(b_busy), 64'b0001);
    @(negedge i_clk);
    check_eq("to_set_a", 64'(a_eto), 64'b0001);
    check_eq("to_set_b", 64'(b_eto), 64'b0001);
    check_eq("to_busy_a", 64'(a_busy), 64'd0);
    err_clr = 1'b1;
    @(negedge i_clk);
    err_clr = 1'b0;
    check_eq("clr_to_a", 64'(a_eto), 64'd0);
    check_eq("clr_ov_b", 64'(b_eov), 64'd0);
    send_beat(8'h07, 4'hF, 4'b0000, 1'b1);

    // Allocation gated by credit, then reset in the middle of a burst.
    path_credit_ok = 4'b1011;
    send_req(8'h10, 32'h0000_0000, 64, 1'b1);
    send_req(8'h11, 32'h0000_0100, 64, 1'b1);
    send_req(8'h12, 32'h0000_0200, 64, 1'b1);
    send_req(8'h13, 32'h0000_0300, 64, 1'b0);
    check_eq("alloc_busy_a", 64'(a_busy), 64'b1011);
    check_eq("alloc_busy_b", 64'(b_busy), 64'b1011);
    send_beat(8'h10, 4'h0, 4'b0000, 1'b0);
    send_beat(8'h10, 4'hF, 4'b0001, 1'b0);
    send_beat(8'h12, 4'hF, 4'b1000, 1'b0);
    #2 i_rst = 1'b1;
    #1;
    check_eq("midrst_idle_a", 64'(a_idle), 64'd1);
    check_eq("midrst_idle_b", 64'(b_idle), 64'd1);
    check_eq("midrst_busy_a", 64'(a_busy), 64'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    path_credit_ok = 4'b1111;
    repeat (5) @(negedge i_clk);
    check_eq("postrst_idle_a", 64'(a_idle), 64'd1);
    check_eq("postrst_err_b", 64'({b_eto, b_eov}), 64'd0);
    check_eq("queue_a_empty", 64'(q_a.size()), 64'd0);
    check_eq("queue_b_empty", 64'(q_b.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
